// File: rtl/student_activity_logger_if.sv
// Bundle between the student FSM state bus / log host and the activity logger.
// The producer/host side is the master; the logger is the slave.
interface student_activity_logger_if #(
  parameter int STATE_W = 5,
  parameter int DUR_W   = 8,
  parameter int DEPTH   = 8,
  parameter int DROP_W  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [STATE_W-1:0] state_in;
  logic               log_en;
  logic               flush;
  logic               rec_ready;
  logic               rec_valid;
  logic [STATE_W-1:0] rec_state;
  logic [DUR_W-1:0]   rec_dur;
  logic [CW-1:0]      fifo_count;
  logic               full;
  logic               overflow;
  logic [DROP_W-1:0]  drop_cnt;
  logic               dbg_primed;

  // Record port: rec_valid/rec_state/rec_dur describe the head record and stay stable
  // until the consumer takes it; a record transfers on any rising edge where
  // rec_valid && rec_ready. rec_ready while rec_valid=0 has no effect.
  modport master (
    output state_in, log_en, flush, rec_ready,
    input  rec_valid, rec_state, rec_dur, fifo_count, full, overflow, drop_cnt, dbg_primed
  );

  modport slave (
    input  state_in, log_en, flush, rec_ready,
    output rec_valid, rec_state, rec_dur, fifo_count, full, overflow, drop_cnt, dbg_primed
  );
endinterface

// File: rtl/student_activity_logger.sv
// Run-length logger for the student FSM state bus: closes a {state, dwell} record per
// segment, buffers it in a small FIFO, and counts records lost to a full FIFO.
module student_activity_logger #(
  parameter int STATE_W = 5,
  parameter int DUR_W   = 8,
  parameter int DEPTH   = 8,
  parameter int DROP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  student_activity_logger_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic {
    TRK_IDLE = 1'b0,
    TRK_RUN  = 1'b1
  } trk_state_e;

  trk_state_e         r_trk_state;
  trk_state_e         w_trk_next;
  logic [STATE_W-1:0] r_cur_state;
  logic [DUR_W-1:0]   r_dwell;
  logic               w_push;
  logic               w_load;
  logic               w_inc;

  logic [STATE_W-1:0] r_mem_state [DEPTH];
  logic [DUR_W-1:0]   r_mem_dur   [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_next;
  logic               r_full;
  logic               r_overflow;
  logic [DROP_W-1:0]  r_drop_cnt;
  logic               w_rec_valid;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  // ---------------- tracker FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_trk_state <= TRK_IDLE;
    else      r_trk_state <= w_trk_next;
  end

  always_comb begin
    w_trk_next = r_trk_state;
    case (r_trk_state)
      TRK_IDLE: if (bus.log_en) w_trk_next = TRK_RUN;
      TRK_RUN:  w_trk_next = TRK_RUN;
      default:  w_trk_next = TRK_IDLE;
    endcase
  end

  // A state change and a flush in the same cycle close the segment only once.
  always_comb begin
    w_push = 1'b0;
    w_load = 1'b0;
    w_inc  = 1'b0;
    if (bus.log_en) begin
      case (r_trk_state)
        TRK_IDLE: w_load = 1'b1;
        TRK_RUN: begin
          if ((bus.state_in != r_cur_state) || bus.flush) begin
            w_push = 1'b1;
            w_load = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_state <= '0;
      r_dwell     <= '0;
    end else if (w_load) begin
      r_cur_state <= bus.state_in;
      r_dwell     <= DUR_W'(1);
    end else if (w_inc && (r_dwell != DUR_MAX)) begin
      r_dwell <= r_dwell + DUR_W'(1);
    end
  end

  // ---------------- record FIFO ----------------
  assign w_rec_valid = (r_count != '0);
  assign w_pop       = w_rec_valid && bus.rec_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_wr        = w_push && (!r_full || w_pop);
  assign w_drop      = w_push && r_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_state[r_wr_ptr] <= r_cur_state;
      r_mem_dur[r_wr_ptr]   <= r_dwell;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != DROP_MAX) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  // Head fields are forced to zero when empty so storage left over after reset never leaks out.
  assign bus.rec_valid  = w_rec_valid;
  assign bus.rec_state  = w_rec_valid ? r_mem_state[r_rd_ptr] : '0;
  assign bus.rec_dur    = w_rec_valid ? r_mem_dur[r_rd_ptr]   : '0;
  assign bus.fifo_count = r_count;
  assign bus.full       = r_full;
  assign bus.overflow   = r_overflow;
  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.dbg_primed = (r_trk_state == TRK_RUN);
endmodule
